// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared types, sizes and the round-robin search helper for the 8:1 mux arbiter.
package rr_mux8_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] index;
  } pick_t;

  // First set request bit in the order ptr+1, ptr+2, ... ptr+8 (mod 8).
  // The loop runs from the farthest candidate down to the nearest, so the
  // last assignment that sticks is the closest one to the pointer.
  function automatic pick_t rr_pick(input logic [N_REQ-1:0] req,
                                    input logic [SEL_W-1:0] ptr);
    pick_t            res;
    logic [SEL_W-1:0] idx;
    res.found = 1'b0;
    res.index = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        res.found = 1'b1;
        res.index = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_mux8_arbiter_if.sv
// Requester/consumer bundle around the 8:1 mux arbiter.
interface rr_mux8_arbiter_if #(parameter int W = 8);
  import rr_mux8_pkg::*;

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] data;
  logic [N_REQ-1:0]   last;
  logic [N_REQ-1:0]   req_ready;
  logic               out_valid;
  logic [W-1:0]       out_data;
  logic               out_last;
  logic               out_ready;
  logic [SEL_W-1:0]   sel;
  logic [N_REQ-1:0]   grant;
  logic               busy;

  // Arbiter side.
  modport slave (
    input  req, data, last, out_ready,
    output req_ready, out_valid, out_data, out_last, sel, grant, busy
  );

  // Requesters plus downstream consumer.
  modport master (
    output req, data, last, out_ready,
    input  req_ready, out_valid, out_data, out_last, sel, grant, busy
  );

endinterface

// File: rtl/rr_mux8_arbiter_mux8_w.sv
// Plain 8:1 case-select of W-bit slices; no gating, the arbiter handles that.
module mux8_w
  import rr_mux8_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [SEL_W-1:0]   sel,
  input  logic [N_REQ*W-1:0] din,
  output logic [W-1:0]       dout
);

  // Select slice sel of the packed input.
  always_comb begin
    dout = '0;
    case (sel)
      3'd0: dout = din[0*W +: W];
      3'd1: dout = din[1*W +: W];
      3'd2: dout = din[2*W +: W];
      3'd3: dout = din[3*W +: W];
      3'd4: dout = din[4*W +: W];
      3'd5: dout = din[5*W +: W];
      3'd6: dout = din[6*W +: W];
      3'd7: dout = din[7*W +: W];
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter for an 8:1 data mux; grant is held for a whole packet.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ARB_IDLE | no owner; pick next requester after ptr, outputs gated to 0
// ARB_BUSY | requester sel owns the channel until a transfer with last=1
module rr_mux8_arbiter
  import rr_mux8_pkg::*;
#(
  parameter int W = 8
) (
  input logic              clk,
  input logic              rst_n,
  rr_mux8_arbiter_if.slave bus
);

  arb_state_t       state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] sel_q;
  logic [N_REQ-1:0] grant_q;
  logic             busy_q;

  logic [W-1:0]     mux_data;
  logic [0:0]       mux_last;
  logic             req_sel;
  logic             xfer;
  pick_t            pick;

  mux8_w #(.W(W)) u_mux_data (
    .sel  (sel_q),
    .din  (bus.data),
    .dout (mux_data)
  );

  mux8_w #(.W(1)) u_mux_last (
    .sel  (sel_q),
    .din  (bus.last),
    .dout (mux_last)
  );

  assign pick    = rr_pick(bus.req, ptr);
  assign req_sel = bus.req[sel_q];
  assign xfer    = (state == ARB_BUSY) && req_sel && bus.out_ready;

  // Arbitration FSM with registered sel/grant/busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ARB_IDLE;
      ptr     <= 3'd7;
      sel_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick.found) begin
            sel_q   <= pick.index;
            grant_q <= N_REQ'(1) << pick.index;
            busy_q  <= 1'b1;
            state   <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (xfer && mux_last[0]) begin
            ptr     <= sel_q;
            grant_q <= '0;
            busy_q  <= 1'b0;
            state   <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Output path: follows the owner in BUSY, forced to zero in IDLE.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    bus.req_ready = '0;
    if (state == ARB_BUSY) begin
      bus.out_valid        = req_sel;
      bus.out_data         = mux_data;
      bus.out_last         = mux_last[0];
      bus.req_ready[sel_q] = bus.out_ready;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Directed bench for rr_mux8_arbiter with hand-computed expectations.
module tb_rr_mux8_arbiter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rr_mux8_arbiter_if #(.W(W)) bus ();

  rr_mux8_arbiter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to 2 time units past the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] v);
    bus.data[i*W +: W] = v;
  endtask

  task automatic chk_owner(input string tag, input int idx);
    chk({tag, " sel"},   32'(bus.sel), 32'(idx));
    chk({tag, " grant"}, 32'(bus.grant), 32'(1) << idx);
    chk({tag, " busy"},  32'(bus.busy), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"},      32'(bus.busy), 32'd0);
    chk({tag, " grant"},     32'(bus.grant), 32'd0);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " out_data"},  32'(bus.out_data), 32'd0);
    chk({tag, " out_last"},  32'(bus.out_last), 32'd0);
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'd0);
  endtask

  initial begin
    bus.req       = '0;
    bus.last      = '0;
    bus.data      = '0;
    bus.out_ready = 1'b0;

    // Reset values, with requests already present.
    #3;
    bus.req       = 8'hFF;
    bus.last      = 8'hFF;
    for (int i = 0; i < 8; i++) set_data(i, 8'hA0 + 8'(i));
    bus.out_ready = 1'b1;
    settle();
    chk_idle("reset");
    chk("reset sel", 32'(bus.sel), 32'd0);
    #8;
    rst_n = 1'b1;

    // Reset priority: all requesting, single-beat packets rotate 0..7 then 0.
    for (int k = 0; k < 9; k++) begin
      step(); settle();
      chk_owner("rr_all", k % 8);
      chk("rr_all data",  32'(bus.out_data), 32'(8'hA0 + 8'(k % 8)));
      chk("rr_all ready", 32'(bus.req_ready), 32'(1) << (k % 8));
      chk("rr_all last",  32'(bus.out_last), 32'd1);
      step(); settle();
      chk_idle("rr_all gap");
      chk("rr_all sel hold", 32'(bus.sel), 32'(k % 8));
    end

    // Pointer now 0. Move it to 5, then bits 0 and 5: 0 wins, then 5.
    bus.req = 8'h20;
    step(); settle();
    chk_owner("to_ptr5", 5);
    bus.req = 8'h21;
    step(); settle();
    chk_idle("to_ptr5 gap");
    step(); settle();
    chk_owner("rr_ptr5", 0);
    step(); settle();
    chk_idle("rr_ptr5 gap");
    step(); settle();
    chk_owner("rr_ptr0", 5);
    step(); settle();
    chk_idle("rr_ptr0 gap");

    // Pointer 5 -> grant 2 alone so pointer becomes 2.
    bus.req = 8'h04;
    step(); settle();
    chk_owner("to_ptr2", 2);

    // Multi-beat from requester 3 while everyone requests.
    bus.req  = 8'hFF;
    bus.last = 8'hF7;
    set_data(3, 8'h11);
    step(); settle();
    chk_idle("mb pre gap");
    step(); settle();
    chk_owner("mb beat1", 3);
    chk("mb beat1 data",  32'(bus.out_data), 32'h11);
    chk("mb beat1 ready", 32'(bus.req_ready), 32'h08);
    chk("mb beat1 last",  32'(bus.out_last), 32'd0);
    step();
    set_data(3, 8'h22);
    settle();
    chk_owner("mb beat2", 3);
    chk("mb beat2 data",  32'(bus.out_data), 32'h22);
    chk("mb beat2 ready", 32'(bus.req_ready), 32'h08);
    step();
    set_data(3, 8'h33);
    bus.last = 8'hFF;
    settle();
    chk_owner("mb beat3", 3);
    chk("mb beat3 data", 32'(bus.out_data), 32'h33);
    chk("mb beat3 last", 32'(bus.out_last), 32'd1);
    step(); settle();
    chk_idle("mb gap");
    step(); settle();
    chk_owner("mb next", 4);

    // Backpressure on requester 4.
    bus.last      = 8'hEF;
    bus.out_ready = 1'b0;
    set_data(4, 8'h5A);
    settle();
    chk("bp last", 32'(bus.out_last), 32'd0);
    for (int c = 0; c < 4; c++) begin
      step(); settle();
      chk_owner("bp stall", 4);
      chk("bp stall data",  32'(bus.out_data), 32'h5A);
      chk("bp stall ready", 32'(bus.req_ready), 32'd0);
      chk("bp stall valid", 32'(bus.out_valid), 32'd1);
    end

    // Owner drops req with last high and out_ready high: no transfer.
    bus.out_ready = 1'b1;
    bus.req       = 8'hEF;
    bus.last      = 8'hFF;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("drop valid", 32'(bus.out_valid), 32'd0);
      chk_owner("drop hold", 4);
      step();
    end
    settle();
    chk_owner("drop after", 4);
    bus.req = 8'hFF;
    settle();
    chk("resume valid", 32'(bus.out_valid), 32'd1);
    chk("resume last",  32'(bus.out_last), 32'd1);
    step(); settle();
    chk_idle("resume gap");

    // Reset in the middle of a 4-beat packet from requester 5.
    step(); settle();
    chk_owner("rst pkt", 5);
    bus.last = 8'hDF;
    step(); settle();
    chk_owner("rst beat2", 5);
    rst_n = 1'b0;
    #1;
    chk_idle("rst async");
    chk("rst async sel", 32'(bus.sel), 32'd0);
    step();
    chk_idle("rst held");
    rst_n = 1'b1;
    bus.last = 8'hFF;
    step(); settle();
    chk_owner("rst after", 0);
    step(); settle();
    chk_idle("rst after gap");

    // No requests: stays idle.
    bus.req = 8'h00;
    step(); step(); settle();
    chk_idle("no req");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rr_mux8_arbiter.md
# rr_mux8_arbiter

Round-robin arbiter and sequencer for an 8:1 data multiplexer. It shares one output channel between eight requesters. It grants one requester at a time, drives the 3-bit mux select, and holds the grant for a whole packet (through the beat marked `last`). It sits in front of the downstream consumer and is the only block that drives the select lines of the 8:1 mux.

## Interface
Parameters:
- `W`, 8: data width per requester and on the output.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 8: requester i has a valid beat on `data[i]`.
- `data`, in, 8*W: packed requester data; slice i is `data[i*W +: W]`.
- `last`, in, 8: requester i's current beat ends its packet.
- `req_ready`, out, 8: beat from requester i accepted this cycle.
- `out_valid`, out, 1: output beat valid.
- `out_data`, out, W: selected requester data.
- `out_last`, out, 1: selected requester's `last`.
- `out_ready`, in, 1: downstream accepts the beat.
- `sel`, out, 3: current grant index, which is the mux select.
- `grant`, out, 8: one-hot grant; all zero when idle.
- `busy`, out, 1: a packet is in progress.

## Operation
- FSM has two states.
  - IDLE: `grant`=0, `busy`=0.
  - BUSY: `grant`=onehot(`sel`), `busy`=1.
- Round-robin pointer `ptr` (3 bits) holds the last winner. Search order is `ptr+1`, `ptr+2`, … `ptr+8` (mod 8).
- IDLE, with any `req` bit set:
  - Pick the first set bit in search order.
  - Register `sel`=winner.
  - Go to BUSY.
- IDLE, with `req`=0: stay in IDLE.
- In BUSY, the following are combinational on `sel`:
  - `out_valid`=`req[sel]`, `out_data`=`data[sel]`, `out_last`=`last[sel]`.
  - `req_ready[sel]`=`out_ready`; every other `req_ready` bit is 0.
- Transfer: `out_valid & out_ready` in BUSY.
- Transfer with `out_last`=1: `ptr`<=`sel`, go to IDLE.
- Transfer with `out_last`=0: stay in BUSY with the same `sel`.
- Granted requester drops `req` mid-packet: `out_valid`=0 and the grant is held. There is no timeout and no preemption.
- Requests from non-granted requesters are ignored until the grant returns to IDLE. Their `req_ready`=0.
- In IDLE: `out_valid`=0, `out_data`=0, `out_last`=0, `req_ready`=0.
- `sel` holds its last value in IDLE. It is not an indicator of ownership; `grant` and `busy` are.

## Timing
- Reset (async assert, sync release) sets:
  - state=IDLE, `ptr`=7 so requester 0 has highest first priority.
  - `sel`=0, `grant`=0, `busy`=0.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `req_ready`=0.
- Arbitration latency: `req` seen in IDLE at cycle n gives `grant`/`busy` high and `out_valid` possible at cycle n+1.
- Throughput: one beat per cycle while `req[sel]` and `out_ready` are both high.
- Packet turnaround: the `last` transfer at cycle n gives IDLE at n+1 and the next grant at n+2. This is exactly one idle cycle between packets, fixed.
- Single-beat packet: one transfer, then IDLE.
- Simultaneous requests: lower search-order distance from `ptr` wins, never fixed priority.
- Reset mid-packet: the packet is abandoned and all outputs go to their reset values immediately. The requester must restart the packet.
- `out_ready` high with `out_valid` low is not a transfer. No state change.

## Structure
- Package `rr_mux8_pkg` holds:
  - `N_REQ`=8 and `SEL_W`=3.
  - State enum `arb_state_t` {ARB_IDLE, ARB_BUSY}.
  - Function `rr_pick(req, ptr)` returning {found, index}.
- Sub-module `mux8_w` (parameter `W`) is the behavioural 8:1 case-select on `sel`. The arbiter instantiates it for the data path and for `last`. Output gating to zero in IDLE is done in the arbiter.
- Target size: about 150-250 lines including the package.

## Test plan
- **Reset priority:** after reset, `req`=8'b1111_1111 → grant to 0 at cycle 1. After its single-beat packet, the next grant is 1, then 2, … 7, then 0.
- **Round robin from pointer:** `ptr`=5 with `req`=8'b0010_0001 (bits 0 and 5) → grant 0, not 5. The packet ends, `ptr`=0, and the next grant is 5.
- **Multi-beat packet:** requester 3 sends data 0x11, 0x22, 0x33 with `last` on 0x33 while `req`=8'hFF → `sel`=3 for all three beats, `req_ready[3]` only, and 1 idle cycle before the next grant (to 4).
- **Backpressure and stall:** `out_ready`=0 for 4 cycles mid-packet → `out_data` stable and no `req_ready` pulses. `req[sel]` dropped for 2 cycles → `out_valid`=0 and the grant is held.
- **Reset mid-packet:** assert `rst_n`=0 during beat 2 of 4 → `grant`, `busy` and `out_valid` go to 0 asynchronously. After release, requester 0 wins if requesting.
